// File: rtl/or_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or_pkg : shared constants and selector state type for or_source_decoder    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package or_pkg;

    localparam int NUM_IN_DEFAULT = 8;
    localparam int IDX_W          = $clog2(NUM_IN_DEFAULT);

    typedef enum logic [0:0] {
        SEL_IDLE  = 1'b0,
        SEL_OFFER = 1'b1
    } sel_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_first_set.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_first_set : first set bit at or above a start pointer, wrapping to 0    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_first_set #(
    parameter int N = 8
) (
    input  logic [N-1:0]         i_vec,
    input  logic [$clog2(N)-1:0] i_start,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);

    localparam int IDX_W = $clog2(N);
    localparam int P     = 1 << IDX_W;

    logic [P-1:0]   w_vec_pad;
    logic [P-1:0]   w_upper_mask;
    logic [P-1:0]   w_vec_hi;
    logic [IDX_W:0] w_hi_res;
    logic [IDX_W:0] w_all_res;

    // Pairwise merge per level: log2(P) levels of 2:1 priority muxes.
    function automatic logic [IDX_W:0] f_first_set(input logic [P-1:0] v);
        logic [P-1:0]     f;
        logic [IDX_W-1:0] ix [P];
        f = v;
        for (int j = 0; j < P; j++) begin
            ix[j] = IDX_W'(j);
        end
        for (int s = 1; s < P; s = s * 2) begin
            for (int j = 0; j < P; j = j + 2 * s) begin
                if (!f[j]) begin
                    ix[j] = ix[j + s];
                end
                f[j] = f[j] | f[j + s];
            end
        end
        return {f[0], ix[0]};
    endfunction

    always_comb begin
        w_vec_pad          = '0;
        w_vec_pad[N-1:0]   = i_vec;
    end

    always_comb begin
        w_upper_mask = '0;
        for (int j = 0; j < P; j++) begin
            w_upper_mask[j] = (j >= int'(i_start));
        end
    end

    assign w_vec_hi  = w_vec_pad & w_upper_mask;
    assign w_hi_res  = f_first_set(w_vec_hi);
    assign w_all_res = f_first_set(w_vec_pad);

    // Nothing at or above the pointer means the search wraps to the lowest set bit.
    assign o_found = w_all_res[IDX_W];
    assign o_idx   = w_hi_res[IDX_W] ? w_hi_res[IDX_W-1:0] : w_all_res[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/or_source_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or_source_decoder : pending-request OR with round-robin source offering    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module or_source_decoder
    import or_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN-1:0]         in,
    input  logic                      clr_all,
    output logic                      any_out,
    output logic                      src_valid,
    output logic [$clog2(NUM_IN)-1:0] src_idx,
    input  logic                      src_ready,
    output logic                      overflow
);

    localparam int                    IDX_BITS   = $clog2(NUM_IN);
    localparam logic [IDX_BITS-1:0]   c_last_idx = IDX_BITS'(NUM_IN - 1);

    sel_state_e            r_state;
    logic [NUM_IN-1:0]     r_pend;
    logic [NUM_IN-1:0]     r_in_prev;
    logic [IDX_BITS-1:0]   r_rr_ptr;
    logic [IDX_BITS-1:0]   r_src_idx;
    logic                  r_any;
    logic                  r_src_valid;
    logic                  r_overflow;

    logic                  w_hs;
    logic [NUM_IN-1:0]     w_drain_mask;
    logic [NUM_IN-1:0]     w_rise;
    logic [NUM_IN-1:0]     w_pend_next;
    logic [NUM_IN-1:0]     w_search_vec;
    logic [IDX_BITS-1:0]   w_ptr_after_hs;
    logic [IDX_BITS-1:0]   w_search_start;
    logic [IDX_BITS-1:0]   w_next_idx;
    logic                  w_next_found;
    logic                  w_ovf_hit;

    assign w_hs           = r_src_valid & src_ready;
    assign w_drain_mask   = w_hs ? (NUM_IN'(1) << r_src_idx) : '0;
    assign w_rise         = in & ~r_in_prev;
    // A new request always wins over both drain and clear of the same bit.
    assign w_pend_next    = clr_all ? in : ((r_pend & ~w_drain_mask) | in);
    assign w_ovf_hit      = |(w_rise & r_pend & ~w_drain_mask);
    assign w_ptr_after_hs = (r_src_idx == c_last_idx) ? '0 : r_src_idx + 1'b1;

    // Idle searches the settled pending set; after a handshake the next offer
    // is chosen from what remains so consecutive handshakes run every cycle.
    assign w_search_vec   = (r_state == SEL_OFFER) ? (r_pend & ~w_drain_mask) : r_pend;
    assign w_search_start = (r_state == SEL_OFFER) ? w_ptr_after_hs : r_rr_ptr;

    rr_first_set #(
        .N (NUM_IN)
    ) u_rr_first_set (
        .i_vec   (w_search_vec),
        .i_start (w_search_start),
        .o_idx   (w_next_idx),
        .o_found (w_next_found)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SEL_IDLE;
            r_pend      <= '0;
            r_in_prev   <= '0;
            r_rr_ptr    <= '0;
            r_src_idx   <= '0;
            r_any       <= 1'b0;
            r_src_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_pend    <= w_pend_next;
            r_in_prev <= in;
            r_any     <= |r_pend;
            if (clr_all) begin
                r_overflow  <= 1'b0;
                r_state     <= SEL_IDLE;
                r_src_valid <= 1'b0;
            end else begin
                if (w_ovf_hit) begin
                    r_overflow <= 1'b1;
                end
                case (r_state)
                    SEL_IDLE: begin
                        if (w_next_found) begin
                            r_state     <= SEL_OFFER;
                            r_src_valid <= 1'b1;
                            r_src_idx   <= w_next_idx;
                        end
                    end
                    SEL_OFFER: begin
                        if (w_hs) begin
                            r_rr_ptr <= w_ptr_after_hs;
                            if (w_next_found) begin
                                r_src_idx <= w_next_idx;
                            end else begin
                                r_state     <= SEL_IDLE;
                                r_src_valid <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state     <= SEL_IDLE;
                        r_src_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign any_out   = r_any;
    assign src_valid = r_src_valid;
    assign src_idx   = r_src_idx;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/or_source_decoder.md
OR_SOURCE_DECODER -- requirements
Module: or_source_decoder

Interface
REQ-001 Parameter NUM_IN, default 8, number of 1-bit request inputs (legal 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in  input  NUM_IN  request lines in1..inN (bit 0 = in1); level-sensitive, sampled every cycle.
REQ-005 clr_all  input  1  one-cycle pulse; discards all pending bits.
REQ-006 any_out  output  1  registered OR of pending bits.
REQ-007 src_valid  output  1  a pending source index is offered.
REQ-008 src_idx  output  clog2(NUM_IN)  offered source index (0 = in1).
REQ-009 src_ready  input  1  consumer accepts src_idx when high with src_valid.
REQ-010 overflow  output  1  sticky flag; a request arrived on an already-pending, not-yet-drained bit.

Function
REQ-011 Pending register pend[NUM_IN] SHALL set bit i on any cycle where in[i]=1; bits stay set until drained or cleared.
REQ-012 any_out SHALL equal OR of pend as registered one cycle after the pend update; latency from in[i] rising to any_out=1 is 2 cycles.
REQ-013 Selector states: IDLE (src_valid=0) and OFFER (src_valid=1).
REQ-014 IDLE -> OFFER on the cycle after pend becomes nonzero; src_idx = first set bit at or above rr_ptr, wrapping from NUM_IN-1 to 0.
REQ-015 In OFFER, src_idx and src_valid SHALL hold stable until handshake (src_valid & src_ready), even if new bits set.
REQ-016 On handshake: clear pend[src_idx]; rr_ptr <= src_idx+1 mod NUM_IN; next cycle re-evaluate: OFFER with next index if pend still nonzero, else IDLE.
REQ-017 Simultaneous handshake clear and in[src_idx]=1 on the same cycle: set wins; bit remains pending, no overflow.
REQ-018 overflow SHALL set when in[i]=1 rising (0->1 sampled edge) while pend[i]=1 and i is not being drained that cycle; clears only on reset or clr_all.
REQ-019 clr_all SHALL zero pend and overflow, force IDLE next cycle, keep rr_ptr; a concurrent in[i]=1 on the same cycle re-sets pend[i] (set wins).
REQ-020 Back-to-back handshakes SHALL sustain one index per cycle while several bits are pending.
REQ-021 Constantly held in[i]=1 SHALL re-set pend[i] every cycle; drained index is re-offered only after every other pending bit has been served in round-robin order.

Reset
REQ-022 When rst_n=0 at a rising edge: pend=0, rr_ptr=0, state=IDLE, any_out=0, src_valid=0, src_idx=0, overflow=0, input edge history=0.
REQ-023 Reset asserted mid-OFFER SHALL abandon the offered index without handshake; in ignored during reset cycles.

Structure
REQ-024 Shared package or_pkg SHALL hold NUM_IN default, IDX_W = clog2(NUM_IN), and the selector state enum.
REQ-025 Round-robin first-set search SHALL be a combinational sub-module rr_first_set (inputs vector, start pointer; outputs index, found), implemented as a log-depth tree, not a linear chain.

Verification
REQ-026 Reset: hold rst_n=0 two cycles with in=8'hFF -> any_out=0, src_valid=0, overflow=0.
REQ-027 Single pulse in[5] one cycle, src_ready=1 -> any_out=1 two cycles later; src_valid with src_idx=5 for exactly one cycle; then IDLE, any_out=0.
REQ-028 Pulse in=8'b1000_0101, rr_ptr=0, src_ready=1 -> src_idx sequence 0,2,7 on consecutive cycles, then IDLE.
REQ-029 Offer idx=3, src_ready=0 for 4 cycles while in[1] pulses -> src_idx stays 3; after ready, next offer is 1 (wrap-around).
REQ-030 Pulse in[4], release, pulse in[4] again before drain -> overflow=1; clr_all pulse -> overflow=0, pend=0, src_valid=0 next cycle.
REQ-031 Handshake on idx 6 with in[6]=1 same cycle -> pend[6] stays set, overflow=0, 6 re-offered after other pending bits.
